// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned, divide-by-zero flag, flush cancel).
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic               sgn_q, sgn_d;
    logic               neg1_q, neg1_d;
    logic               neg2_q, neg2_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     shifted;
    logic               take;
    logic [WIDTH-1:0]   rem_step, quot_step, q_fin, r_fin;

    always_comb begin
        a_neg = signed_i & opdata1_i[WIDTH-1];
        b_neg = signed_i & opdata2_i[WIDTH-1];
        a_mag = a_neg ? -opdata1_i : opdata1_i;
        b_mag = b_neg ? -opdata2_i : opdata2_i;

        // Shifted remainder needs one extra bit before the trial subtract.
        shifted   = {rem_q, dvd_q[WIDTH-1]};
        take      = (shifted >= {1'b0, dvs_q});
        rem_step  = take ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        quot_step = {dvd_q[WIDTH-2:0], take};
        q_fin     = (sgn_q & (neg1_q ^ neg2_q)) ? -quot_step : quot_step;
        r_fin     = (sgn_q & neg1_q) ? -rem_step : rem_step;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        op1_d    = op1_q;
        sgn_d    = sgn_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        dz_d     = dz_q;

        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    op1_d  = opdata1_i;
                    dvd_d  = a_mag;
                    dvs_d  = b_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                    sgn_d  = signed_i;
                    neg1_d = a_neg;
                    neg2_d = b_neg;
                    if (opdata2_i == '0) begin
                        state_d = DIVZERO;
`ifdef DIV_EARLY_OUT_EN
                    end else if (a_mag < b_mag) begin
                        state_d  = END;
                        result_d = {opdata1_i, {WIDTH{1'b0}}};
                        dz_d     = 1'b0;
`endif
                    end else begin
                        state_d = ON;
                    end
                end
            end
            DIVZERO: begin
                if (annul_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    dz_d     = 1'b0;
                end else begin
                    state_d  = END;
                    result_d = {op1_q, {WIDTH{1'b1}}};
                    dz_d     = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    dz_d     = 1'b0;
                end else begin
                    rem_d = rem_step;
                    dvd_d = quot_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = END;
                        result_d = {r_fin, q_fin};
                        dz_d     = 1'b0;
                    end
                end
            end
            END: begin
                if (annul_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    dz_d     = 1'b0;
                end else if (!start_i) begin
                    state_d = IDLE;
                    dz_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            op1_q    <= '0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            op1_q    <= op1_d;
            sgn_q    <= sgn_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = (state_q == END);
    assign busy_o     = (state_q != IDLE);
    assign div_zero_o = dz_q;
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle iterative radix-2 restoring divider, parametrised in operand width.
- Serves DIV/DIVU in the EX stage. EX holds `stallreq` high while `busy_o` is high, then writes `result_o` into HI/LO.
- Supports signed and unsigned modes, divide-by-zero detection and cancellation (`annul_i`) on pipeline flush.

Parameters:
- WIDTH, 32, operand width in bits. Iteration counter width is ceil(log2(WIDTH+1)).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- signed_i  input  1  1 = signed division, 0 = unsigned
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  request a division; held high by EX until result is taken
- annul_i  input  1  cancel the operation in progress (flush)
- result_o  output  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO
- ready_o  output  1  result_o valid
- busy_o  output  1  state != IDLE
- div_zero_o  output  1  valid with ready_o; divisor was zero

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. `result_o`=0, `ready_o`=0, `busy_o`=0, `div_zero_o`=0. Reset overrides all other inputs, mid-operation included.
- States: IDLE, DIVZERO, ON, END.
- IDLE, start_i=1 and annul_i=0:
  - Latch operands and signed_i at this edge; later input changes are ignored.
  - If divisor==0, go to DIVZERO.
  - Otherwise, go to ON with counter=0.
  - Signed mode latches absolute values (two's complement) plus the sign of the dividend and the sign of the divisor.
- IDLE, start_i=1 and annul_i=1: ignored, stay in IDLE.
- DIVZERO: next edge goes to END.
  - result_o = {latched opdata1_i, all-ones}.
  - div_zero_o=1.
- ON: one quotient bit per cycle, MSB first.
  - Shift partial remainder left by 1 and bring in the next dividend bit.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit=1; otherwise set the bit to 0.
  - After exactly WIDTH cycles (counter reaches WIDTH-1 at the edge), go to END.
- Entering END, ON path:
  - Quotient is negated if signed_i and the latched signs differ.
  - Remainder is negated if signed_i and the dividend was negative.
  - result_o is registered; div_zero_o=0.
- END: ready_o=1, result_o held stable. Stay until start_i=0, then go to IDLE.
- IDLE output rules: ready_o=0 and div_zero_o=0. result_o keeps its last value; it is not cleared.
- Latency, measured in edges from the accepting edge until ready_o=1:
  - Normal: WIDTH+1.
  - Divide by zero: 2.
- annul_i=1 in DIVZERO, ON or END: next edge goes to IDLE, ready_o=0, result_o=0. Same-edge start_i is not accepted.
- Overflow case: signed most-negative / -1 gives quotient = most-negative (wraps), remainder 0. No exception is raised.
- start_i still high in IDLE right after END → IDLE transition is impossible: END exits only on start_i=0.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, when divisor≠0 and |dividend| < |divisor| (magnitudes per mode), skip ON and go straight to END at the next edge.
  - result_o = {opdata1_i, 0}.
  - Latency is 1.
- Undefined: such operands run the full WIDTH iterations. The result is identical; only latency differs.

Test Plan:
- WIDTH=32, unsigned 100/7 → result_o={0x2, 0xE}, ready_o at edge 33, busy_o high edges 1–33.
- Signed 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Same operands unsigned → quotient 0x7FFFFFFC, remainder 0x1.
- 5/0 → result_o={0x5, 0xFFFFFFFF}, div_zero_o=1, ready_o at edge 2. Holding start_i for 5 more cycles keeps outputs stable; dropping start_i returns to IDLE.
- Start 9/3, pulse annul_i at cycle 10 → next edge busy_o=0, ready_o never asserted. Fresh start 9/3 → {0x0, 0x3} at edge 33. Repeat with rst asserted mid-ON instead of annul_i: same recovery.
- Signed 0x80000000 / 0xFFFFFFFF → {0x0, 0x80000000}, no error indication.
- Unsigned 3/10 → {0x3, 0x0}. With DIV_EARLY_OUT_EN, ready_o at edge 1; without it, at edge 33.
